hour_cnt: RTL and testbench



---
 rtl/hour_cnt_pkg.sv | 86 ++++++++
 rtl/key_repeat.sv | 77 +++++++
 rtl/hour_cnt.sv | 75 +++++++
 tb/tb_hour_cnt.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hour_cnt_pkg.sv
// Shared types, constants and BCD helpers for the hour counter.
// Optional 12-hour display outputs in the top are enabled by defining HOURCNT_12H_EN.
package hour_cnt_pkg;

    typedef enum logic [1:0] {
        RS_IDLE,
        RS_DELAY,
        RS_REPEAT
    } rep_state_t;

    localparam logic [1:0] HOUR_TENS_TOP = 2'd2;
    localparam logic [3:0] HOUR_ONES_TOP = 4'd3;
    localparam logic [3:0] BCD_MAX       = 4'd9;

    typedef struct packed {
        logic [1:0] tens;
        logic [3:0] ones;
    } bcd_hour_t;

    typedef struct packed {
        logic       pm;
        logic       tens;
        logic [3:0] ones;
    } hour12_t;

    function automatic logic hour_valid(input bcd_hour_t h);
        return ((h.tens < HOUR_TENS_TOP) && (h.ones <= BCD_MAX)) ||
               ((h.tens == HOUR_TENS_TOP) && (h.ones <= HOUR_ONES_TOP));
    endfunction

    // Any encoding outside 00-23 falls back to 00 on the next advance.
    function automatic bcd_hour_t next_hour(input bcd_hour_t h);
        bcd_hour_t n;
        n = '0;
        if (!hour_valid(h) ||
            ((h.tens == HOUR_TENS_TOP) && (h.ones == HOUR_ONES_TOP))) begin
            n = '0;
        end else if (h.ones == BCD_MAX) begin
            n.tens = h.tens + 2'd1;
            n.ones = 4'd0;
        end else begin
            n.tens = h.tens;
            n.ones = h.ones + 4'd1;
        end
        return n;
    endfunction

    function automatic hour12_t to_12h(input bcd_hour_t h);
        hour12_t r;
        r = '0;
        case (h.tens)
            2'd0: begin
                if (h.ones == 4'd0) begin
                    r.tens = 1'b1;
                    r.ones = 4'd2;
                end else begin
                    r.ones = h.ones;
                end
            end
            2'd1: begin
                if (h.ones <= 4'd1) begin
                    r.tens = 1'b1;
                    r.ones = h.ones;
                end else if (h.ones == 4'd2) begin
                    r.pm   = 1'b1;
                    r.tens = 1'b1;
                    r.ones = 4'd2;
                end else begin
                    r.pm   = 1'b1;
                    r.ones = h.ones - 4'd2;
                end
            end
            default: begin
                r.pm = 1'b1;
                if (h.ones <= 4'd1) begin
                    r.ones = h.ones + 4'd8;
                end else begin
                    r.tens = 1'b1;
                    r.ones = h.ones - 4'd2;
                end
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Button edge-detect plus hold-to-auto-repeat: one PULSE on press, then
// periodic pulses while held. Shared by the hour and minute set paths.
module key_repeat
    import hour_cnt_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int TMR_W         = 26
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic PULSE
);

    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
    localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);

    rep_state_t       state;
    logic [TMR_W-1:0] timer;
    logic             btn_q;
    logic             rise;

    assign rise = BTN & ~btn_q;

    // btn_q resets high so a button held through reset must be re-pressed.
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= RS_IDLE;
            timer <= '0;
            btn_q <= 1'b1;
            PULSE <= 1'b0;
        end else begin
            btn_q <= BTN;
            PULSE <= 1'b0;
            case (state)
                RS_IDLE: begin
                    timer <= '0;
                    if (rise) begin
                        PULSE <= 1'b1;
                        state <= RS_DELAY;
                    end
                end
                RS_DELAY: begin
                    if (!BTN) begin
                        state <= RS_IDLE;
                        timer <= '0;
                    end else if (timer == DELAY_LAST) begin
                        PULSE <= 1'b1;
                        timer <= '0;
                        state <= RS_REPEAT;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                RS_REPEAT: begin
                    if (!BTN) begin
                        state <= RS_IDLE;
                        timer <= '0;
                    end else if (timer == PERIOD_LAST) begin
                        PULSE <= 1'b1;
                        timer <= '0;
                    end else begin
                        timer <= timer + TMR_ONE;
                    end
                end
                default: begin
                    state <= RS_IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hour_cnt.sv
// BCD 00-23 hour counter advanced by the minute carry or the set button.
// Define HOURCNT_12H_EN to add combinational 12-hour outputs PM/DH/DL.
module hour_cnt
    import hour_cnt_pkg::*;
#(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int TMR_W         = 26
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       INC_BTN,
    output logic [1:0] QH,
    output logic [3:0] QL,
    output logic       CA,
    output logic       INC_PULSE
`ifdef HOURCNT_12H_EN
    ,
    output logic       PM,
    output logic       DH,
    output logic [3:0] DL
`endif
);

    bcd_hour_t hour_q;
    bcd_hour_t hour_d;
    logic      adv;

    key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .TMR_W        (TMR_W)
    ) u_key_repeat (
        .CLK  (CLK),
        .RST  (RST),
        .BTN  (INC_BTN),
        .PULSE(INC_PULSE)
    );

    // A minute carry and a set pulse in the same cycle advance only once.
    assign adv = EN | INC_PULSE;

    // NOTE: default assignment first keeps this combinational block latch-free.
    always_comb begin
        hour_d = hour_q;
        if (adv) begin
            hour_d = next_hour(hour_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hour_q <= '0;
        end else begin
            hour_q <= hour_d;
        end
    end

    assign QH = hour_q.tens;
    assign QL = hour_q.ones;

    // Day carry follows the minute carry only; setting past 23 never carries.
    assign CA = EN && (hour_q.tens == HOUR_TENS_TOP) && (hour_q.ones == HOUR_ONES_TOP);

`ifdef HOURCNT_12H_EN
    hour12_t h12;

    assign h12 = to_12h(hour_q);
    assign PM  = h12.pm;
    assign DH  = h12.tens;
    assign DL  = h12.ones;
`endif

endmodule

// File: tb/tb_hour_cnt.sv
// Self-checking bench for hour_cnt with short repeat timing (delay 8, period 4).
module tb_hour_cnt;

    logic       CLK;
    logic       RST;
    logic       EN;
    logic       INC_BTN;
    logic [1:0] QH;
    logic [3:0] QL;
    logic       CA;
    logic       INC_PULSE;
`ifdef HOURCNT_12H_EN
    logic       PM;
    logic       DH;
    logic [3:0] DL;
`endif

    int checks   = 0;
    int failures = 0;
    int hour     = 0;

    hour_cnt #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4),
        .TMR_W        (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .INC_BTN  (INC_BTN),
        .QH       (QH),
        .QL       (QL),
        .CA       (CA),
        .INC_PULSE(INC_PULSE)
`ifdef HOURCNT_12H_EN
        ,
        .PM       (PM),
        .DH       (DH),
        .DL       (DL)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic       btn;
        logic [1:0] qh;
        logic [3:0] ql;
        logic       ca;
        logic       pulse;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic en, input logic btn,
                                input logic [1:0] qh, input logic [3:0] ql,
                                input logic ca, input logic pulse);
        vec_t v;
        v.rst = rst; v.en = en; v.btn = btn;
        v.qh = qh; v.ql = ql; v.ca = ca; v.pulse = pulse;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_hour(input string name, input int h);
        check({name, "_qh"}, 32'(QH), 32'(h / 10));
        check({name, "_ql"}, 32'(QL), 32'(h % 10));
    endtask

    // Inputs change just after a rising edge; outputs are sampled on the falling edge.
    task automatic drive(input logic en, input logic btn, input logic rst);
        EN = en; INC_BTN = btn; RST = rst;
        @(negedge CLK);
    endtask

    task automatic next_edge;
        @(posedge CLK);
        #1;
    endtask

    task automatic en_steps(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            next_edge();
            hour = (hour + 1) % 24;
        end
    endtask

`ifdef HOURCNT_12H_EN
    typedef struct {
        int   h24;
        logic dh;
        logic [3:0] dl;
        logic pm;
    } h12_vec_t;
`endif

    initial begin
        EN = 1'b0; INC_BTN = 1'b0; RST = 1'b1;
        next_edge();

        // Test 1: reset state, then a full day of minute carries.
        drive(1'b0, 1'b0, 1'b1);
        next_edge();
        drive(1'b0, 1'b0, 1'b0);
        check_hour("reset", 0);
        check("reset_pulse", 32'(INC_PULSE), 32'd0);
        check("reset_ca", 32'(CA), 32'd0);
        next_edge();
        hour = 0;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            check($sformatf("t1_ca_en_%0d", hour), 32'(CA), (hour == 23) ? 32'd1 : 32'd0);
            check_hour($sformatf("t1_hold_%0d", hour), hour);
            next_edge();
            hour = (hour + 1) % 24;
            for (int j = 0; j < 2; j++) begin
                drive(1'b0, 1'b0, 1'b0);
                check($sformatf("t1_ca_idle_%0d", hour), 32'(CA), 32'd0);
                check_hour($sformatf("t1_step_%0d", hour), hour);
                next_edge();
            end
        end

        // Tests 3/4 as a cycle table: single press, reset, then a 20-cycle hold.
        add(0, 0, 1, 2'd0, 4'd0, 0, 0);
        add(0, 0, 0, 2'd0, 4'd0, 0, 1);
        add(0, 0, 0, 2'd0, 4'd1, 0, 0);
        add(0, 0, 0, 2'd0, 4'd1, 0, 0);
        add(1, 0, 0, 2'd0, 4'd1, 0, 0);
        add(0, 0, 0, 2'd0, 4'd0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            logic p;
            int   cnt;
            p   = (k == 1) || (k == 9) || (k == 13) || (k == 17);
            cnt = int'(k > 1) + int'(k > 9) + int'(k > 13) + int'(k > 17);
            add(0, 0, 1, 2'd0, 4'(cnt), 0, p);
        end
        for (int k = 0; k < 6; k++) begin
            add(0, 0, 0, 2'd0, 4'd4, 0, 0);
        end
        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].btn, vecs[i].rst);
            check($sformatf("vec%0d_qh", i), 32'(QH), 32'(vecs[i].qh));
            check($sformatf("vec%0d_ql", i), 32'(QL), 32'(vecs[i].ql));
            check($sformatf("vec%0d_ca", i), 32'(CA), 32'(vecs[i].ca));
            check($sformatf("vec%0d_pulse", i), 32'(INC_PULSE), 32'(vecs[i].pulse));
            next_edge();
        end

        // Test 5a: setting 23 -> 00 via the button gives no day carry.
        drive(1'b0, 1'b0, 1'b1);
        next_edge();
        hour = 0;
        en_steps(23);
        drive(1'b0, 1'b0, 1'b0);
        check_hour("t5_at23", 23);
        next_edge();
        drive(1'b0, 1'b1, 1'b0);
        next_edge();
        drive(1'b0, 1'b0, 1'b0);
        check("t5_set_pulse", 32'(INC_PULSE), 32'd1);
        check("t5_set_no_ca", 32'(CA), 32'd0);
        next_edge();
        drive(1'b0, 1'b0, 1'b0);
        check_hour("t5_set_wrap", 0);
        next_edge();
        hour = 0;

        // Test 5b: EN coincident with a set pulse at 23 advances exactly once.
        en_steps(23);
        drive(1'b0, 1'b1, 1'b0);
        check_hour("t5_at23_again", 23);
        next_edge();
        drive(1'b1, 1'b1, 1'b0);
        check("t5_coinc_pulse", 32'(INC_PULSE), 32'd1);
        check("t5_coinc_ca", 32'(CA), 32'd1);
        next_edge();
        drive(1'b0, 1'b1, 1'b0);
        check_hour("t5_single_adv", 0);
        check("t5_after_pulse", 32'(INC_PULSE), 32'd0);
        next_edge();

        // Test 5c: button held across reset release produces nothing until re-pressed.
        drive(1'b0, 1'b1, 1'b1);
        next_edge();
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0);
            check($sformatf("t5_held_pulse_%0d", k), 32'(INC_PULSE), 32'd0);
            check_hour($sformatf("t5_held_%0d", k), 0);
            next_edge();
        end
        drive(1'b0, 1'b0, 1'b0);
        next_edge();
        drive(1'b0, 1'b1, 1'b0);
        next_edge();
        drive(1'b0, 1'b0, 1'b0);
        check("t5_repress_pulse", 32'(INC_PULSE), 32'd1);
        next_edge();
        drive(1'b0, 1'b0, 1'b0);
        check_hour("t5_repress_hour", 1);
        check("t5_repress_done", 32'(INC_PULSE), 32'd0);
        next_edge();

`ifdef HOURCNT_12H_EN
        begin
            h12_vec_t h12v[5];
            h12v[0] = '{0,  1'b1, 4'd2, 1'b0};
            h12v[1] = '{11, 1'b1, 4'd1, 1'b0};
            h12v[2] = '{12, 1'b1, 4'd2, 1'b1};
            h12v[3] = '{13, 1'b0, 4'd1, 1'b1};
            h12v[4] = '{23, 1'b1, 4'd1, 1'b1};
            drive(1'b0, 1'b0, 1'b1);
            next_edge();
            hour = 0;
            foreach (h12v[i]) begin
                en_steps(h12v[i].h24 - hour);
                drive(1'b0, 1'b0, 1'b0);
                check_hour($sformatf("t6_h%0d", h12v[i].h24), h12v[i].h24);
                check($sformatf("t6_dh_%0d", h12v[i].h24), 32'(DH), 32'(h12v[i].dh));
                check($sformatf("t6_dl_%0d", h12v[i].h24), 32'(DL), 32'(h12v[i].dl));
                check($sformatf("t6_pm_%0d", h12v[i].h24), 32'(PM), 32'(h12v[i].pm));
                next_edge();
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
